// File: rtl/rdata_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : rdata_packetizer
// Purpose  : Buffers DDR read-data beats in a small FIFO and emits them as
//            fixed-length AXI-Stream packets. Tracks outstanding reads to
//            drive a read credit, counts overflow drops and flags
//            unexpected beats. A flush pulse ends the current packet early.
// Options  : define RDATA_TIMEOUT_FLUSH_EN to add an idle-timeout flush.
// Revision : 1.0 - initial release
// ============================================================================
module rdata_packetizer #(
  parameter int DATA_WIDTH     = 512,
  parameter int DEPTH          = 16,
  parameter int PKT_BEATS      = 8,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_issue,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic                      rdata_en,
  input  logic                      flush,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      rd_credit,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [$clog2(DEPTH):0]    inflight_count,
  output logic [CNT_WIDTH-1:0]      drop_count,
  output logic                      err_unexp
);

  localparam int              c_aw        = $clog2(DEPTH);
  localparam int              c_bw        = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [c_aw:0]   c_depth     = (c_aw+1)'(DEPTH);
  localparam logic [c_aw:0]   c_one       = (c_aw+1)'(1);
  localparam logic [c_bw-1:0] c_last_beat = c_bw'(PKT_BEATS - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw:0]         wr_ptr_q, wr_ptr_d;
  logic [c_aw:0]         rd_ptr_q, rd_ptr_d;
  logic [c_bw-1:0]       beat_cnt_q, beat_cnt_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  tlast_hold_q, tlast_hold_d;
  logic [c_aw:0]         inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  drop_q, drop_d;
  logic                  err_q, err_d;

  logic [c_aw:0] w_count;
  logic          w_valid;
  logic          w_full;
  logic          w_push;
  logic          w_xfer;
  logic          w_last;
  logic          w_fp_clr;
  logic          w_tmo_fire;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count  = wr_ptr_q - rd_ptr_q;
  assign w_valid  = (w_count != '0);
  assign w_full   = (w_count == c_depth);
  assign w_push   = rdata_en && !w_full;
  assign w_xfer   = w_valid && m_axis_tready;
  // A latched tlast keeps the packet end pinned while the sink stalls, even
  // if a late beat makes the flush-end condition go false.
  assign w_last   = w_valid && (tlast_hold_q || (beat_cnt_q == c_last_beat) ||
                    (flush_pend_q && (w_count == c_one) && (inflight_q == '0)));
  // Nothing left to terminate: drop the pending flush instead of emitting an
  // empty packet.
  assign w_fp_clr = (w_xfer && w_last) ||
                    (!w_valid && (inflight_q == '0) && (beat_cnt_q == '0));

  assign m_axis_tvalid  = w_valid;
  assign m_axis_tlast   = w_last;
  assign m_axis_tdata   = w_valid ? mem_q[rd_ptr_q[c_aw-1:0]] : '0;
  assign m_axis_tkeep   = '1;
  assign fifo_count     = w_count;
  assign inflight_count = inflight_q;
  assign drop_count     = drop_q;
  assign err_unexp      = err_q;
  assign rd_credit      = ({1'b0, w_count} + {1'b0, inflight_q}) < {1'b0, c_depth};

`ifdef RDATA_TIMEOUT_FLUSH_EN
  localparam int              c_tw      = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_tw-1:0] c_tmo_max = c_tw'(TIMEOUT_CYCLES - 1);

  logic [c_tw-1:0] tmo_q, tmo_d;

  // Idle timer: runs while a packet is open or data waits, restarts on activity.
  always_comb begin
    tmo_d      = tmo_q;
    w_tmo_fire = 1'b0;
    if (rdata_en || w_xfer) begin
      tmo_d = '0;
    end else if ((beat_cnt_q != '0) || w_valid) begin
      if (tmo_q == c_tmo_max) begin
        w_tmo_fire = 1'b1;
        tmo_d      = '0;
      end else begin
        tmo_d = tmo_q + c_tw'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Idle timer register.
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign w_tmo_fire = 1'b0;
`endif

  // Next-state logic for pointers, packet tracking and read bookkeeping.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + (w_push ? c_one : '0);
    rd_ptr_d     = rd_ptr_q + (w_xfer ? c_one : '0);
    beat_cnt_d   = beat_cnt_q;
    if (w_xfer) beat_cnt_d = w_last ? '0 : beat_cnt_q + c_bw'(1);
    tlast_hold_d = w_last && !m_axis_tready;
    flush_pend_d = (flush_pend_q && !w_fp_clr) || flush || w_tmo_fire;
    drop_d       = drop_q;
    if (rdata_en && w_full && (drop_q != '1)) drop_d = drop_q + CNT_WIDTH'(1);
    inflight_d   = inflight_q;
    err_d        = err_q;
    if (rd_issue && !rdata_en) begin
      if (inflight_q != c_depth) inflight_d = inflight_q + c_one;
    end else if (!rd_issue && rdata_en) begin
      if (inflight_q == '0) err_d = 1'b1;
      else                  inflight_d = inflight_q - c_one;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      tlast_hold_q <= 1'b0;
      inflight_q   <= '0;
      drop_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      flush_pend_q <= flush_pend_d;
      tlast_hold_q <= tlast_hold_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      err_q        <= err_d;
    end
  end

  // Beat storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q[c_aw-1:0]] <= rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_rdata_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rdata_packetizer
// Purpose  : Self-checking bench for rdata_packetizer: vector table, directed
//            multi-cycle sequences and a randomized run against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rdata_packetizer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int PKT   = 8;
  localparam int TMO   = 16;
  localparam int CW    = 4;
  localparam int AW    = 4;

  logic            clk = 1'b0;
  logic            rst, rd_issue, rdata_en, flush, tready;
  logic [DW-1:0]   rdata, tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast, tvalid, credit, err;
  logic [AW:0]     fcnt, icnt;
  logic [CW-1:0]   dcnt;

  rdata_packetizer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_BEATS(PKT),
    .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .rd_issue(rd_issue), .rdata(rdata),
    .rdata_en(rdata_en), .flush(flush), .m_axis_tdata(tdata),
    .m_axis_tkeep(tkeep), .m_axis_tlast(tlast), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .rd_credit(credit), .fifo_count(fcnt),
    .inflight_count(icnt), .drop_count(dcnt), .err_unexp(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int            xfer_n;
  int            last_idx[$];
  logic [DW-1:0] out_data[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int last_at(input int k);
    return (k < last_idx.size()) ? last_idx[k] : -1;
  endfunction

  function automatic logic [DW-1:0] data_at(input int k);
    return (k < out_data.size()) ? out_data[k] : '1;
  endfunction

  task automatic clear_mon();
    xfer_n = 0;
    last_idx.delete();
    out_data.delete();
  endtask

  // Record the handshake the coming edge performs, clock once, clear pulses.
  task automatic step();
    if (tvalid === 1'b1 && tready === 1'b1) begin
      xfer_n++;
      out_data.push_back(tdata);
      if (tlast === 1'b1) last_idx.push_back(xfer_n);
    end
    @(posedge clk);
    #1;
    rd_issue = 1'b0;
    rdata_en = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tready = 1'b0; rd_issue = 1'b0; rdata_en = 1'b0; flush = 1'b0; rdata = '0;
    step();
    step();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin rd_issue = 1'b1; step(); end
  endtask

  task automatic push_n(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      rdata_en = 1'b1; rdata = base + DW'(i); step();
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic          iss, en, fl, rdy;
    logic [DW-1:0] d;
    logic          e_v, e_l;
    logic [DW-1:0] e_d;
    int            e_f, e_i;
    logic          e_err;
  } vec_t;

  function automatic vec_t mk(input logic iss, en, fl, rdy, input logic [DW-1:0] d,
                              input logic ev, el, input logic [DW-1:0] ed,
                              input int ef, ei, input logic eerr);
    vec_t v;
    v.iss = iss; v.en = en; v.fl = fl; v.rdy = rdy; v.d = d;
    v.e_v = ev; v.e_l = el; v.e_d = ed; v.e_f = ef; v.e_i = ei; v.e_err = eerr;
    return v;
  endfunction

  // Reference model state
  logic [DW-1:0] mq[$];
  int            m_infl, m_drop, m_bcnt, m_tmo;
  logic          m_fpend, m_hold, m_err;

  function automatic logic m_tlast();
    return (mq.size() > 0) &&
           (m_hold || (m_bcnt == PKT - 1) || (m_fpend && mq.size() == 1 && m_infl == 0));
  endfunction

  task automatic model_update(input logic iss, en, fl, rdy, input logic [DW-1:0] d);
    logic tv, tl, xf, clr, fire, full;
    tv   = (mq.size() > 0);
    tl   = m_tlast();
    xf   = tv && rdy;
    clr  = (xf && tl) || (mq.size() == 0 && m_infl == 0 && m_bcnt == 0);
    full = (mq.size() == DEPTH);
    fire = 1'b0;
`ifdef RDATA_TIMEOUT_FLUSH_EN
    if (en || xf) m_tmo = 0;
    else if (m_bcnt != 0 || tv) begin
      if (m_tmo == TMO - 1) begin fire = 1'b1; m_tmo = 0; end
      else m_tmo++;
    end else m_tmo = 0;
`endif
    if (xf) begin
      void'(mq.pop_front());
      m_bcnt = tl ? 0 : m_bcnt + 1;
    end
    if (en) begin
      if (!full) mq.push_back(d);
      else if (m_drop < (1 << CW) - 1) m_drop++;
    end
    if (iss && !en) begin
      if (m_infl < DEPTH) m_infl++;
    end else if (!iss && en) begin
      if (m_infl == 0) m_err = 1'b1;
      else m_infl--;
    end
    m_hold  = tl && !rdy;
    m_fpend = (m_fpend && !clr) || fl || fire;
  endtask

  vec_t tbl[12];

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1; tready = 1'b0; rd_issue = 1'b0; rdata_en = 1'b0; flush = 1'b0; rdata = '0;
    step();
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tdata", tdata, 0);
    chk("rst_fifo", fcnt, 0);
    chk("rst_credit", credit, 1'b1);
    chk("rst_infl", icnt, 0);
    chk("rst_drop", dcnt, 0);
    chk("rst_err", err, 1'b0);
    chk("rst_tkeep", tkeep, 4'hF);
    step();
    rst = 1'b0;
    clear_mon();

    // ---------------- vector table ----------------
    //            iss en fl rdy data    v  l  tdata   f  i  err
    tbl[0]  = mk(1, 0, 0, 0, 0,       0, 0, 0,      0, 1, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0,       0, 0, 0,      0, 2, 0);
    tbl[2]  = mk(0, 1, 0, 0, 'hA1,    1, 0, 'hA1,   1, 1, 0);
    tbl[3]  = mk(1, 1, 0, 0, 'hA2,    1, 0, 'hA1,   2, 1, 0);
    tbl[4]  = mk(0, 0, 0, 1, 0,       1, 0, 'hA2,   1, 1, 0);
    tbl[5]  = mk(0, 0, 1, 0, 0,       1, 0, 'hA2,   1, 1, 0);
    tbl[6]  = mk(0, 1, 0, 0, 'hA3,    1, 0, 'hA2,   2, 0, 0);
    tbl[7]  = mk(0, 0, 0, 1, 0,       1, 1, 'hA3,   1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0,       1, 1, 'hA3,   1, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 'hA4,    1, 1, 'hA3,   2, 0, 1);
    tbl[10] = mk(0, 0, 0, 1, 0,       1, 0, 'hA4,   1, 0, 1);
    tbl[11] = mk(0, 0, 0, 1, 0,       0, 0, 0,      0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      rd_issue = tbl[i].iss; rdata_en = tbl[i].en; flush = tbl[i].fl;
      tready = tbl[i].rdy; rdata = tbl[i].d;
      step();
      chk($sformatf("vec%0d_tvalid", i), tvalid, tbl[i].e_v);
      chk($sformatf("vec%0d_tlast", i), tlast, tbl[i].e_l);
      chk($sformatf("vec%0d_tdata", i), tdata, tbl[i].e_d);
      chk($sformatf("vec%0d_fifo", i), fcnt, tbl[i].e_f);
      chk($sformatf("vec%0d_infl", i), icnt, tbl[i].e_i);
      chk($sformatf("vec%0d_err", i), err, tbl[i].e_err);
    end

    // ---------------- two full packets ----------------
    do_reset();
    tready = 1'b1;
    issue_n(16);
    push_n(16, 1);
    idle_n(4);
    chk("pkt2_xfers", xfer_n, 16);
    chk("pkt2_nlast", last_idx.size(), 2);
    chk("pkt2_last0", last_at(0), 8);
    chk("pkt2_last1", last_at(1), 16);
    chk("pkt2_infl", icnt, 0);
    chk("pkt2_err", err, 1'b0);

    // ---------------- overflow and saturation ----------------
    do_reset();
    tready = 1'b0;
    issue_n(16);
    push_n(18, 1);
    chk("ovf_fifo", fcnt, 16);
    chk("ovf_drop", dcnt, 2);
    chk("ovf_credit", credit, 1'b0);
    push_n(20, 'h100);
    chk("ovf_drop_sat", dcnt, 15);
    chk("ovf_fifo_sat", fcnt, 16);
    tready = 1'b1;
    idle_n(18);
    chk("ovf_xfers", xfer_n, 16);
    for (int i = 0; i < 16; i++) chk($sformatf("ovf_data%0d", i), data_at(i), i + 1);
    chk("ovf_last0", last_at(0), 8);
    chk("ovf_last1", last_at(1), 16);

    // ---------------- flush of a short packet ----------------
    do_reset();
    tready = 1'b0;
    issue_n(3);
    push_n(3, 'h31);
    flush = 1'b1;
    step();
    tready = 1'b1;
    idle_n(5);
    chk("fl_xfers", xfer_n, 3);
    chk("fl_nlast", last_idx.size(), 1);
    chk("fl_last0", last_at(0), 3);
    issue_n(8);
    push_n(8, 'h40);
    idle_n(3);
    chk("fl_next_xfers", xfer_n, 11);
    chk("fl_next_last", last_at(1), 11);

    // ---------------- reset mid-packet ----------------
    issue_n(5);
    push_n(3, 'h50);
    tready = 1'b0;
    push_n(2, 'h60);
    do_reset();
    chk("mid_fifo", fcnt, 0);
    chk("mid_tvalid", tvalid, 1'b0);
    chk("mid_infl", icnt, 0);
    tready = 1'b1;
    issue_n(8);
    push_n(8, 'h70);
    idle_n(3);
    chk("mid_xfers", xfer_n, 8);
    chk("mid_last", last_at(0), 8);
    chk("mid_first", data_at(0), 'h70);

    // ---------------- idle timeout ----------------
    do_reset();
    tready = 1'b0;
    issue_n(5);
    push_n(5, 'h80);
    idle_n(17);
    tready = 1'b1;
    idle_n(7);
    chk("tmo_xfers", xfer_n, 5);
`ifdef RDATA_TIMEOUT_FLUSH_EN
    chk("tmo_nlast", last_idx.size(), 1);
    chk("tmo_last0", last_at(0), 5);
`else
    chk("tmo_nlast", last_idx.size(), 0);
`endif

    // ---------------- randomized run against the model ----------------
    do_reset();
    mq.delete();
    m_infl = 0; m_drop = 0; m_bcnt = 0; m_tmo = 0;
    m_fpend = 1'b0; m_hold = 1'b0; m_err = 1'b0;
    begin
      int rdy_p, iss_p;
      logic ri, re, rf, rr;
      logic [DW-1:0] rd;
      rdy_p = 4; iss_p = 1;
      for (int c = 0; c < 3000; c++) begin
        chk("rnd_tvalid", tvalid, mq.size() > 0);
        chk("rnd_tlast", tlast, m_tlast());
        chk("rnd_tdata", tdata, (mq.size() > 0) ? mq[0] : '0);
        chk("rnd_fifo", fcnt, mq.size());
        chk("rnd_infl", icnt, m_infl);
        chk("rnd_credit", credit, (mq.size() + m_infl) < DEPTH);
        chk("rnd_drop", dcnt, m_drop);
        chk("rnd_err", err, m_err);
        if (c % 250 == 0) begin
          rdy_p = $urandom_range(0, 4);
          iss_p = $urandom_range(1, 3);
        end
        ri = ($urandom_range(0, 3) < iss_p);
        re = (m_infl > 0) && ($urandom_range(0, 1) == 1);
        rf = ($urandom_range(0, 39) == 0);
        rr = ($urandom_range(0, 3) < rdy_p);
        rd = $urandom;
        rd_issue = ri; rdata_en = re; flush = rf; tready = rr; rdata = rd;
        model_update(ri, re, rf, rr, rd);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
